// File: rtl/cla_adder_pkg.sv
// Shared constants and the 4-input lookahead equations for the carry-lookahead adder.
// Both lookahead levels use the same equations, so they live here.
// Contents: CLA_BLOCK_W, CLA_GROUP_W, cla_la_t, lookahead4().
package cla_adder_pkg;

  localparam int CLA_BLOCK_W = 4;   // bits per level-1 lookahead block
  localparam int CLA_GROUP_W = 16;  // bits per level-2 lookahead group (4 blocks)

  // Result of one 4-wide lookahead evaluation:
  //   c[3:1] - carries into positions 1..3, relative to the carry-in c0
  //   gg/pp  - generate/propagate of the whole 4-wide span
  typedef struct packed {
    logic [3:1] c;
    logic       gg;
    logic       pp;
  } cla_la_t;

  // Two-level sum-of-products lookahead. Every carry is computed directly
  // from g/p and c0, so no carry depends on another carry.
  function automatic cla_la_t lookahead4(input logic [3:0] g,
                                         input logic [3:0] p,
                                         input logic       c0);
    cla_la_t r;
    r.c[1] = g[0]
           | (p[0] & c0);
    r.c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & c0);
    r.c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
    r.gg   = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    r.pp   = &p;
    return r;
  endfunction

endpackage

// File: rtl/cla_adder_cla4_block.sv
// cla4_block: combinational 4-bit carry-lookahead block; no latency, no flow control.
// Ports: a[3:0], b[3:0], cin -> s[3:0] sum bits, g/p block generate/propagate.
// The block's carry-out is not produced here; the level-2 unit derives it from g/p.
module cla4_block
  import cla_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);

  logic [3:0] gb;
  logic [3:0] pb;
  cla_la_t    la;

  assign gb = a & b;
  assign pb = a ^ b;
  assign la = lookahead4(gb, pb, cin);

  // Carry vector into each bit position: bit 0 takes the block carry-in.
  assign s  = pb ^ {la.c, cin};
  assign g  = la.gg;
  assign p  = la.pp;

endmodule

// File: rtl/cla_adder.sv
// cla_adder: registered WIDTH-bit carry-lookahead adder, {cout, s} = a + b + cin.
// Latency 1 cycle, one operation per cycle, no stall or backpressure.
// Ports: clk, rst (async high), in_valid/a/b/cin in; s/cout/out_valid out (all from flops).
module cla_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  localparam int NBLK = WIDTH / CLA_BLOCK_W;
  localparam int NGRP = WIDTH / CLA_GROUP_W;

  if (((WIDTH % CLA_GROUP_W) != 0) || (WIDTH < CLA_GROUP_W)) begin : g_bad_width
    $error("cla_adder: WIDTH must be a multiple of 16 and at least 16");
  end

  logic [NBLK-1:0]  blk_g;
  logic [NBLK-1:0]  blk_p;
  logic [NBLK-1:0]  blk_cin;
  logic [NGRP:0]    grp_c;    // grp_c[j] = carry into group j, grp_c[NGRP] = carry-out
  logic [WIDTH-1:0] sum_c;

  assign grp_c[0] = cin;

  // Level 1: 4-bit lookahead blocks.
  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    cla4_block u_blk (
      .a   (a[CLA_BLOCK_W*i +: CLA_BLOCK_W]),
      .b   (b[CLA_BLOCK_W*i +: CLA_BLOCK_W]),
      .cin (blk_cin[i]),
      .s   (sum_c[CLA_BLOCK_W*i +: CLA_BLOCK_W]),
      .g   (blk_g[i]),
      .p   (blk_p[i])
    );
  end

  // Level 2: one lookahead unit per 16-bit group feeds its four block
  // carry-ins; groups then chain on their own G/P.
  for (genvar j = 0; j < NGRP; j++) begin : g_grp
    cla_la_t la;

    assign la = lookahead4(blk_g[4*j +: 4], blk_p[4*j +: 4], grp_c[j]);

    assign blk_cin[4*j]     = grp_c[j];
    assign blk_cin[4*j + 1] = la.c[1];
    assign blk_cin[4*j + 2] = la.c[2];
    assign blk_cin[4*j + 3] = la.c[3];

    assign grp_c[j+1] = la.gg | (la.pp & grp_c[j]);
  end

  // Output register. The sum is only sampled when in_valid is high, so
  // whatever sits on a/b while idle never reaches s/cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum_c;
        cout <= grp_c[NGRP];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;

  logic [63:0] s64;
  logic        cout64;
  logic        ov64;
  logic [31:0] s32;
  logic        cout32;
  logic        ov32;
  logic [15:0] s16;
  logic        cout16;
  logic        ov16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .s(s64), .cout(cout64), .out_valid(ov64)
  );

  cla_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[31:0]), .b(b[31:0]), .cin(cin),
    .s(s32), .cout(cout32), .out_valid(ov32)
  );

  cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[15:0]), .b(b[15:0]), .cin(cin),
    .s(s16), .cout(cout16), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the 64-bit instance: {cout, s} and out_valid.
  task automatic check64(input string tag, input logic [64:0] exp_sum, input logic exp_ov);
    check({tag, "_sum"}, {cout64, s64}, exp_sum);
    check({tag, "_ov"}, {64'd0, ov64}, {64'd0, exp_ov});
  endtask

  task automatic drive(input logic v, input logic [63:0] av, input logic [63:0] bv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [64:0] m64;
  logic [32:0] m32;
  logic [16:0] m16;
  logic        mv;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check64("reset", 65'd0, 1'b0);
    check("reset32", {32'd0, ov32, s32}, 65'd0);
    check("reset16", {48'd0, ov16, s16}, 65'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Simple add, then back-to-back directed vectors.
    drive(1'b1, 64'd5, 64'd5, 1'b0);
    tick(); check64("5+5", 65'd10, 1'b1);
    drive(1'b1, 64'd9, 64'd9, 1'b1);
    tick(); check64("9+9+1", 65'd19, 1'b1);
    drive(1'b1, 64'd7, 64'd7, 1'b1);
    tick(); check64("7+7+1", 65'd15, 1'b1);
    drive(1'b1, 64'd31, 64'd16, 1'b1);
    tick(); check64("31+16+1", 65'd48, 1'b1);

    // Hold: idle cycles with garbage operands leave the result alone.
    drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    tick(); check64("hold_rand", 65'd48, 1'b0);
    drive(1'b0, 'x, 'x, 1'bx);
    tick(); check64("hold_x", 65'd48, 1'b0);

    // Full-width propagation.
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    tick(); check64("ones+0+1", {1'b1, 64'd0}, 1'b1);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick(); check64("ones+ones+1", {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    drive(1'b1, 64'd0, 64'd0, 1'b0);
    tick(); check64("0+0", 65'd0, 1'b1);

    // Group / block boundaries.
    drive(1'b1, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    tick(); check64("grp_boundary", 65'h0_0000_0000_0001_0000, 1'b1);
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    tick(); check64("msb_carry", {1'b1, 64'd0}, 1'b1);
    drive(1'b1, 64'h0000_0000_0000_000F, 64'd0, 1'b1);
    tick(); check64("blk_boundary", 65'h10, 1'b1);

    // Reset mid-stream, between clock edges.
    drive(1'b1, 64'd1, 64'd2, 1'b0);
    tick(); check64("pre_rst", 65'd3, 1'b1);
    drive(1'b1, 64'd100, 64'd200, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check64("rst_async", 65'd0, 1'b0);
    tick(); check64("rst_hold", 65'd0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 64'd100, 64'd200, 1'b0);
    tick(); check64("post_rst_idle", 65'd0, 1'b0);
    drive(1'b1, 64'd100, 64'd200, 1'b0);
    tick(); check64("post_rst_first", 65'd300, 1'b1);

    // Random, all three widths, with an independent hold model.
    m64 = {cout64, s64};
    m32 = 33'(300);
    m16 = 17'(300);
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 7) != 0), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      if (i % 97 == 0) begin
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'($urandom_range(0, 1));
      end
      mv = in_valid;
      if (in_valid) begin
        m64 = {1'b0, a} + {1'b0, b} + 65'(cin);
        m32 = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(cin);
        m16 = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(cin);
      end
      tick();
      check("rnd64", {cout64, s64}, m64);
      check("rnd32", {31'd0, ov32, cout32, s32}, {31'd0, mv, m32});
      check("rnd16", {47'd0, ov16, cout16, s16}, {47'd0, mv, m16});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
